// File: rtl/fc_act_unit.sv
// fc_act_unit
// Elastic two-stage activation stage between the FC core result stream and
// the FC data loader write-back path. Each 16-bit signed fixed-point element
// is registered in S1 and then activated into S2; S2 drives the output port.
// The stage tags the final element of a layer and pulses done after it leaves.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cfg_load, cfg_act_type, cfg_count  start/abort a layer, latch its config
//   din_valid, din_ready, din_data     upstream element stream
//   dout_valid, dout_ready, dout_data  downstream result stream
//   dout_last                          final element of the layer
//   done                               one-cycle pulse after the last result leaves
module fc_act_unit #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int CNT_W     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_load,
  input  logic [4:0]        cfg_act_type,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  output logic              done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [4:0] ACT_RELU  = 5'd1;
  localparam logic [4:0] ACT_LEAKY = 5'd2;
  localparam logic [4:0] ACT_HSIG  = 5'd3;
  localparam logic [4:0] ACT_HTANH = 5'd4;

  // Fixed-point 1.0 and 0.5, one bit wider than the data so sums cannot wrap.
  localparam int                    ONE_I  = 32'sd1 << FRAC_BITS;
  localparam logic signed [DATA_W:0] ONE_X  = ONE_I[DATA_W:0];
  localparam logic signed [DATA_W:0] HALF_X = ONE_X >>> 1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Activation of one element; evaluated on a sign-extended copy so that the
  // hard-sigmoid offset and all clamps are computed without overflow.
  function automatic logic [DATA_W-1:0] act_fn(input logic [DATA_W-1:0] x,
                                               input logic [4:0]        code);
    logic signed [DATA_W:0] xs;
    logic signed [DATA_W:0] t;
    logic signed [DATA_W:0] res;
    xs  = {x[DATA_W-1], x};
    t   = (xs >>> 2) + HALF_X;
    res = xs;
    case (code)
      ACT_RELU:  res = xs[DATA_W] ? '0 : xs;
      ACT_LEAKY: res = xs[DATA_W] ? (xs >>> 3) : xs;
      ACT_HSIG: begin
        if (t[DATA_W])      res = '0;
        else if (t > ONE_X) res = ONE_X;
        else                res = t;
      end
      ACT_HTANH: begin
        if (xs < -ONE_X)     res = -ONE_X;
        else if (xs > ONE_X) res = ONE_X;
        else                 res = xs;
      end
      default:   res = xs;
    endcase
    return res[DATA_W-1:0];
  endfunction

  logic [0:0]        state_q,    state_d;
  logic [4:0]        act_q,      act_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic [CNT_W-1:0]  in_cnt_q,   in_cnt_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [CNT_W-1:0]  s1_idx_q,   s1_idx_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q,  s2_data_d;
  logic              s2_last_q,  s2_last_d;
  logic              done_q,     done_d;

  logic s2_free;
  logic s1_free;
  logic in_hs;
  logic out_hs;

  // Handshake and stage-advance qualifiers; din_ready depends on dout_ready.
  always_comb begin
    s2_free   = !s2_valid_q || dout_ready;
    s1_free   = !s1_valid_q || s2_free;
    din_ready = (state_q == ST_RUN) && (in_cnt_q < count_q) && !cfg_load && s1_free;
    in_hs     = din_valid && din_ready;
    out_hs    = s2_valid_q && dout_ready;
  end

  // Next-state: config latch/abort, layer control and pipeline movement.
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    count_d    = count_q;
    in_cnt_d   = in_cnt_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_idx_d   = s1_idx_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_last_d  = s2_last_q;
    done_d     = 1'b0;
    if (cfg_load) begin
      // Abort whatever is in flight; the aborted layer never reports done.
      act_d      = cfg_act_type;
      count_d    = cfg_count;
      in_cnt_d   = '0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      state_d    = (cfg_count != '0) ? ST_RUN : ST_IDLE;
    end else begin
      if (s2_free) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_data_d = act_fn(s1_data_q, act_q);
          s2_last_d = (s1_idx_q == count_q - CNT_ONE);
        end else begin
          s2_data_d = s2_data_q;
          s2_last_d = s2_last_q;
        end
      end else begin
        s2_valid_d = s2_valid_q;
      end
      if (s1_free) begin
        s1_valid_d = in_hs;
        if (in_hs) begin
          s1_data_d = din_data;
          s1_idx_d  = in_cnt_q;
        end else begin
          s1_data_d = s1_data_q;
          s1_idx_d  = s1_idx_q;
        end
      end else begin
        s1_valid_d = s1_valid_q;
      end
      in_cnt_d = in_hs ? (in_cnt_q + CNT_ONE) : in_cnt_q;
      if (out_hs && s2_last_q) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        done_d  = 1'b0;
      end
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      act_q      <= 5'd0;
      count_q    <= '0;
      in_cnt_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      count_q    <= count_d;
      in_cnt_q   <= in_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_last_q  <= s2_last_d;
      done_q     <= done_d;
    end
  end

  assign dout_valid = s2_valid_q;
  assign dout_data  = s2_data_q;
  assign dout_last  = s2_valid_q && s2_last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fc_act_unit.sv
// Self-checking bench for fc_act_unit: directed layers plus randomized data,
// compared against an arithmetic reference of the activation rules.
module tb_fc_act_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_load = 1'b0;
  logic [4:0]  cfg_act_type = 5'd0;
  logic [11:0] cfg_count = 12'd0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] din_data = 16'd0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [15:0] dout_data;
  logic        dout_last;
  logic        done;

  int errors = 0;
  int checks = 0;

  int n_in = 0, n_out = 0, done_cnt = 0;
  int edge_cnt = 0;
  int first_in_edge = 0, first_out_edge = 0, last_out_edge = 0, done_edge = 0;
  int got_data[$];
  int got_last[$];
  int stim_q[$];
  logic        stall_prev = 1'b0;
  logic [15:0] prev_data = 16'd0;
  logic        prev_last = 1'b0;

  fc_act_unit #(.DATA_W(16), .FRAC_BITS(8), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_load(cfg_load), .cfg_act_type(cfg_act_type), .cfg_count(cfg_count),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last), .done(done)
  );

  always #5 clk = ~clk;

  // Edge counter used to time events.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference activation, written directly from the arithmetic rules.
  function automatic int ref_act(input int x, input int code);
    int t;
    case (code)
      1: return (x < 0) ? 0 : x;
      2: return (x < 0) ? -((-x + 7) / 8) : x;          // floor(x/8)
      3: begin
        t = ((x >= 0) ? (x / 4) : -((-x + 3) / 4)) + 128; // floor(x/4) + 0.5
        if (t < 0) return 0;
        if (t > 256) return 256;
        return t;
      end
      4: return (x < -256) ? -256 : ((x > 256) ? 256 : x);
      default: return x;
    endcase
  endfunction

  // Monitor: observes handshakes mid-cycle (they complete at the next edge).
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (din_valid && din_ready) begin
        if (n_in == 0) first_in_edge = edge_cnt;
        n_in++;
      end
      if (stall_prev) begin
        chk("stall_valid", int'(dout_valid), 1);
        chk("stall_data", int'(dout_data), int'(prev_data));
        chk("stall_last", int'(dout_last), int'(prev_last));
      end
      if (dout_valid && dout_ready) begin
        if (n_out == 0) first_out_edge = edge_cnt;
        last_out_edge = edge_cnt;
        got_data.push_back(int'($signed(dout_data)));
        got_last.push_back(int'(dout_last));
        n_out++;
      end
      if (done) begin
        done_cnt++;
        done_edge = edge_cnt;
      end
      stall_prev = dout_valid && !dout_ready && !cfg_load;
      prev_data  = dout_data;
      prev_last  = dout_last;
    end
  end

  task automatic cfg_pulse(input int code, input int cnt);
    @(posedge clk); #1;
    n_in = 0; n_out = 0; done_cnt = 0;
    got_data.delete(); got_last.delete();
    cfg_load = 1'b1; cfg_act_type = 5'(code); cfg_count = 12'(cnt);
    din_valid = 1'b0; dout_ready = 1'b0;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    cfg_act_type = 5'($urandom); cfg_count = 12'($urandom);
  endtask

  // rmode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random.
  task automatic run_layer(input int code, input int cnt, input int rmode, input string tag);
    int cyc;
    int v;
    cfg_pulse(code, cnt);
    cyc = 0;
    while (done_cnt == 0 && cyc < 40 * cnt + 50) begin
      din_valid = (n_in < stim_q.size()) && (rmode != 2 || $urandom_range(0, 2) != 0);
      v = (n_in < stim_q.size()) ? stim_q[n_in] : int'($urandom);
      din_data = v[15:0];
      case (rmode)
        0: dout_ready = 1'b1;
        1: dout_ready = (cyc % 3 == 0);
        default: dout_ready = 1'(($urandom));
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " accepted"}, n_in, cnt);
    chk({tag, " produced"}, n_out, cnt);
    chk({tag, " done_timing"}, done_edge - last_out_edge, 1);
    chk({tag, " din_ready_after"}, int'(din_ready), 0);
    for (int k = 0; k < cnt; k++) begin
      if (k < got_data.size()) begin
        chk($sformatf("%s data[%0d]", tag, k), got_data[k], ref_act(stim_q[k], code));
        chk($sformatf("%s last[%0d]", tag, k), got_last[k], (k == cnt - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int code, cnt;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst dout_valid", int'(dout_valid), 0);
    chk("rst din_ready", int'(din_ready), 0);
    chk("rst done", int'(done), 0);
    chk("rst dout_last", int'(dout_last), 0);
    chk("rst dout_data", int'(dout_data), 0);
    rst_n = 1'b1;

    // 1: start a layer, reset mid-stream, then RELU boundary vectors.
    cfg_pulse(0, 5);
    din_valid = 1'b1; din_data = 16'd1234; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst dout_valid", int'(dout_valid), 0);
    chk("midrst din_ready", int'(din_ready), 0);
    chk("midrst dout_data", int'(dout_data), 0);
    din_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    stim_q = '{-5, 0, 7, -32768};
    run_layer(1, 4, 0, "relu");
    chk("relu latency", first_out_edge - first_in_edge, 2);
    chk("relu back_to_back", last_out_edge - first_out_edge, 3);

    // 2: LEAKY_RELU.
    stim_q = '{-16, -1, 100};
    run_layer(2, 3, 0, "leaky");

    // 3: HARD_SIGMOID.
    stim_q = '{0, 512, 1024, -1024, 32767};
    run_layer(3, 5, 0, "hsig");

    // 4: HARD_TANH under a 1,0,0 ready pattern with random data.
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back($signed(16'($urandom)) / ((i % 2) ? 1 : 64));
    stim_q[0] = -32768;
    run_layer(4, 8, 1, "htanh");

    // 5: abort a count=6 layer after 3 accepts, then a NONE layer of 2.
    stim_q = '{11, 22, 33, 44, 55, 66};
    cfg_pulse(1, 6);
    for (int c = 0; c < 50 && n_in < 3; c++) begin
      din_valid = 1'b1; din_data = 16'(stim_q[n_in]); dout_ready = 1'b1;
      @(posedge clk); #1;
    end
    din_valid = 1'b0; dout_ready = 1'b0;
    chk("abort accepted", n_in, 3);
    chk("abort no_done", done_cnt, 0);
    stim_q = '{-300, 301};
    run_layer(0, 2, 0, "after_abort");

    // 6: zero-count layer accepts nothing; code 7 acts as NONE.
    cfg_pulse(3, 0);
    din_valid = 1'b1; din_data = 16'd77; dout_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("zero din_ready", int'(din_ready), 0);
      chk("zero dout_valid", int'(dout_valid), 0);
      chk("zero done", int'(done), 0);
    end
    din_valid = 1'b0;
    stim_q = '{-12345};
    run_layer(7, 1, 0, "code7");

    // Randomized layers: random code (including unused codes) and data.
    for (int l = 0; l < 6; l++) begin
      code = (l < 5) ? l : int'($urandom_range(5, 31));
      cnt  = int'($urandom_range(1, 20));
      stim_q.delete();
      for (int i = 0; i < cnt; i++) stim_q.push_back(int'($signed(16'($urandom))));
      run_layer(code, cnt, 2, $sformatf("rand%0d", l));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
